// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the riscv32i core. Detects register
// hazards between ID and the EX/MEM/WB stages. Drives hold, bubble and flush
// controls for the PC and the inter-stage registers. Produces the branch
// redirect for the PC, plus the EX operand-forwarding selects. Also runs an
// orderly halt drain before freezing the core.
//
// Optional feature macro: PIPE_HAZARD_CTRL_FWD_EN
//   defined   : EX operands are forwarded from MEM/WB, so only load-use
//               hazards stall the front end.
//   undefined : no forwarding (selects tied to 0). Any outstanding RAW
//               dependency against EX, MEM or WB stalls until it retires.

module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,

    input  logic [4:0]  ex_rd,
    input  logic        ex_we,
    input  logic        ex_is_load,

    input  logic [4:0]  mem_rd,
    input  logic        mem_we,

    input  logic [4:0]  wb_rd,
    input  logic        wb_we,

    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_halt,

    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // The drain counter is 4 bits wide, which covers the legal 1..15 range.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    // Forwarding select encodings as seen by the EX operand muxes.
    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEM_ALU = 2'd1;
    localparam logic [1:0] FWD_WB_DATA = 2'd2;

    state_t     state;
    logic [3:0] drain_cnt;
    logic       halted_q;

    logic       rs1_ex_match;
    logic       rs2_ex_match;
    logic       rs1_mem_match;
    logic       rs2_mem_match;
    logic       raw_hazard;

    // A source only depends on a stage when it is actually read, the stage
    // writes that register, and the register is not x0. x0 is hard-wired
    // to zero, so it can never carry a stale value.
    function automatic logic src_match(
        input logic       use_src,
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       dst_we
    );
        return use_src && dst_we && (src == dst) && (src != 5'd0);
    endfunction

    assign rs1_ex_match  = src_match(id_use_rs1, id_rs1, ex_rd,  ex_we);
    assign rs2_ex_match  = src_match(id_use_rs2, id_rs2, ex_rd,  ex_we);
    assign rs1_mem_match = src_match(id_use_rs1, id_rs1, mem_rd, mem_we);
    assign rs2_mem_match = src_match(id_use_rs2, id_rs2, mem_rd, mem_we);

`ifdef PIPE_HAZARD_CTRL_FWD_EN

    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // WB results reach EX through the register file write, so WB is never
    // a hazard when forwarding is present.
    logic       unused_wb_ports;
    assign unused_wb_ports = &{1'b0, wb_rd, wb_we};

    // Only a load in EX is too late to forward. Everything else is covered
    // by the MEM/WB bypass paths.
    assign raw_hazard = ex_is_load && (rs1_ex_match || rs2_ex_match);

    // Pick the bypass the ID instruction will need once it reaches EX.
    // The EX producer is the youngest, so it wins over MEM.
    always_comb begin
        fwd_a_next = FWD_REGFILE;
        fwd_b_next = FWD_REGFILE;
        if (rs1_ex_match && !ex_is_load) begin
            fwd_a_next = FWD_MEM_ALU;
        end else if (rs1_mem_match) begin
            fwd_a_next = FWD_WB_DATA;
        end
        if (rs2_ex_match && !ex_is_load) begin
            fwd_b_next = FWD_MEM_ALU;
        end else if (rs2_mem_match) begin
            fwd_b_next = FWD_WB_DATA;
        end
    end

    // Capture the selects as the instruction moves into EX. A bubble
    // carries no operands and therefore reads the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_sel <= FWD_REGFILE;
            fwd_b_sel <= FWD_REGFILE;
        end else if (bubble_ex) begin
            fwd_a_sel <= FWD_REGFILE;
            fwd_b_sel <= FWD_REGFILE;
        end else begin
            fwd_a_sel <= fwd_a_next;
            fwd_b_sel <= fwd_b_next;
        end
    end

`else

    logic rs1_wb_match;
    logic rs2_wb_match;

    // Without bypass paths, the load/ALU distinction does not matter.
    logic unused_load_flag;
    assign unused_load_flag = &{1'b0, ex_is_load};

    assign rs1_wb_match = src_match(id_use_rs1, id_rs1, wb_rd, wb_we);
    assign rs2_wb_match = src_match(id_use_rs2, id_rs2, wb_rd, wb_we);

    // The consumer must wait until its producer has left WB, so any
    // match in EX, MEM or WB holds ID.
    assign raw_hazard = rs1_ex_match  || rs2_ex_match  ||
                        rs1_mem_match || rs2_mem_match ||
                        rs1_wb_match  || rs2_wb_match;

    assign fwd_a_sel = FWD_REGFILE;
    assign fwd_b_sel = FWD_REGFILE;

`endif

    // Zero-latency pipeline controls, derived from the current state and the
    // stage inputs. A halt outranks a branch, which outranks a hazard stall.
    always_comb begin
        stall_if_id    = 1'b0;
        bubble_ex      = 1'b0;
        flush_if_id    = 1'b0;
        redirect_valid = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (ex_halt) begin
                        stall_if_id = 1'b1;
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (ex_branch_taken) begin
                        redirect_valid = 1'b1;
                        flush_if_id    = 1'b1;
                        bubble_ex      = 1'b1;
                    end else if (raw_hazard) begin
                        stall_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    stall_if_id = 1'b1;
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end
                ST_HALTED: begin
                    stall_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end
                default: begin
                    stall_if_id = 1'b0;
                end
            endcase
        end
        redirect_pc = redirect_valid ? ex_target : 32'd0;
    end

    // Halt sequencing. An accepted halt loads the drain counter, and the
    // core is frozen once the counter runs out. Only reset leaves HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= 4'd0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_halt) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt <= 4'd1) begin
                        drain_cnt <= 4'd0;
                        state     <= ST_HALTED;
                        halted_q  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                ST_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= 4'd0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Each scenario is a table of
// per-cycle stimulus with the expected controls for that cycle. Each row
// also gives the forwarding selects expected one cycle later. Those are
// queued and popped when the registered selects become visible.
// Expectations follow PIPE_HAZARD_CTRL_FWD_EN in the same way the design does.

module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [4:0] STALL = 5'b11000;

    typedef struct packed {
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  exrd;
        logic        exwe;
        logic        exld;
        logic [4:0]  memrd;
        logic        memwe;
        logic [4:0]  wbrd;
        logic        wbwe;
        logic        br;
        logic [31:0] tgt;
        logic        halt;
    } stim_t;

    // ctl order: {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted}
    typedef struct packed {
        stim_t       s;
        logic        rst;
        logic [4:0]  ctl;
        logic [31:0] pc;
        logic [3:0]  nf;
    } row_t;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        ex_branch_taken;
    logic [31:0] ex_target;
    logic        ex_halt;
    logic        stall_if_id;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        halted;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb[$];

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES(3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_we           (ex_we),
        .ex_is_load      (ex_is_load),
        .mem_rd          (mem_rd),
        .mem_we          (mem_we),
        .wb_rd           (wb_rd),
        .wb_we           (wb_we),
        .ex_branch_taken (ex_branch_taken),
        .ex_target       (ex_target),
        .ex_halt         (ex_halt),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input int rs1, input int u1, input int rs2, input int u2,
                                 input int exrd, input int exwe, input int exld,
                                 input int memrd, input int memwe, input int wbrd, input int wbwe,
                                 input int br, input logic [31:0] tgt, input int halt);
        stim_t s;
        s.rs1   = 5'(rs1);
        s.u1    = 1'(u1);
        s.rs2   = 5'(rs2);
        s.u2    = 1'(u2);
        s.exrd  = 5'(exrd);
        s.exwe  = 1'(exwe);
        s.exld  = 1'(exld);
        s.memrd = 5'(memrd);
        s.memwe = 1'(memwe);
        s.wbrd  = 5'(wbrd);
        s.wbwe  = 1'(wbwe);
        s.br    = 1'(br);
        s.tgt   = tgt;
        s.halt  = 1'(halt);
        return s;
    endfunction

    function automatic row_t rw(input stim_t s, input int rst, input logic [4:0] ctl,
                                input logic [31:0] pc, input logic [3:0] nf);
        row_t r;
        r.s   = s;
        r.rst = 1'(rst);
        r.ctl = ctl;
        r.pc  = pc;
        r.nf  = nf;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        id_rs1          = s.rs1;
        id_use_rs1      = s.u1;
        id_rs2          = s.rs2;
        id_use_rs2      = s.u2;
        ex_rd           = s.exrd;
        ex_we           = s.exwe;
        ex_is_load      = s.exld;
        mem_rd          = s.memrd;
        mem_we          = s.memwe;
        wb_rd           = s.wbrd;
        wb_we           = s.wbwe;
        ex_branch_taken = s.br;
        ex_target       = s.tgt;
        ex_halt         = s.halt;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        @(negedge clk);
        reset = 1'b1;
        drive(mk(5, 1, 5, 1, 5, 1, 1, 5, 1, 5, 1, 1, 32'h40, 1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset ctl got=%b want=%b", obs, 5'b00000);
        end
        total++;
        if (redirect_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset redirect_pc got=%h want=%h", redirect_pc, 32'h0);
        end
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'h0) begin
            bad++;
            $display("[TB] FAIL reset fwd got=%b want=%b", {fwd_a_sel, fwd_b_sel}, 4'h0);
        end
        sb.delete();
        sb.push_back(4'h0);
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [4:0] obs;
        logic [3:0] ef;
        rows.push_back(rw(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, STALL, 0, 4'h0));
        rows.push_back(rw(mk(5, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, FWD ? 4'b1000 : 4'h0));
        rows.push_back(rw(mk(0, 0, 9, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 12, 1, 12, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, STALL, 0, 4'h0));
        rows.push_back(rw(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(6, 1, 6, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        foreach (rows[i]) begin
            @(negedge clk);
            reset = rows[i].rst;
            drive(rows[i].s);
            #1;
            obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
            total++;
            if (obs !== rows[i].ctl) begin
                bad++;
                $display("[TB] FAIL load_use ctl row %0d got=%b want=%b", i, obs, rows[i].ctl);
            end
            total++;
            if (redirect_pc !== rows[i].pc) begin
                bad++;
                $display("[TB] FAIL load_use redirect_pc row %0d got=%h want=%h", i, redirect_pc, rows[i].pc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL load_use fwd row %0d got=empty scoreboard want=entry", i);
            end else begin
                ef = sb.pop_front();
                if ({fwd_a_sel, fwd_b_sel} !== ef) begin
                    bad++;
                    $display("[TB] FAIL load_use fwd row %0d got=%b want=%b", i, {fwd_a_sel, fwd_b_sel}, ef);
                end
            end
            sb.push_back(rows[i].nf);
        end
    endtask

    task automatic test_alu_fwd();
        row_t rows[$];
        logic [4:0] obs;
        logic [3:0] ef;
        rows.push_back(rw(mk(0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, FWD ? 4'b0001 : 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(4, 1, 6, 1, 6, 1, 0, 4, 1, 0, 0, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, FWD ? 4'b1001 : 4'h0));
        rows.push_back(rw(mk(8, 1, 0, 0, 8, 1, 0, 8, 1, 0, 0, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, FWD ? 4'b0100 : 4'h0));
        rows.push_back(rw(mk(9, 0, 10, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(11, 1, 11, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        foreach (rows[i]) begin
            @(negedge clk);
            reset = rows[i].rst;
            drive(rows[i].s);
            #1;
            obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
            total++;
            if (obs !== rows[i].ctl) begin
                bad++;
                $display("[TB] FAIL alu_fwd ctl row %0d got=%b want=%b", i, obs, rows[i].ctl);
            end
            total++;
            if (redirect_pc !== rows[i].pc) begin
                bad++;
                $display("[TB] FAIL alu_fwd redirect_pc row %0d got=%h want=%h", i, redirect_pc, rows[i].pc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL alu_fwd fwd row %0d got=empty scoreboard want=entry", i);
            end else begin
                ef = sb.pop_front();
                if ({fwd_a_sel, fwd_b_sel} !== ef) begin
                    bad++;
                    $display("[TB] FAIL alu_fwd fwd row %0d got=%b want=%b", i, {fwd_a_sel, fwd_b_sel}, ef);
                end
            end
            sb.push_back(rows[i].nf);
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [4:0] obs;
        logic [3:0] ef;
        rows.push_back(rw(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 32'h0000_0040, 0), 0, 5'b01110, 32'h40, 4'h0));
        rows.push_back(rw(mk(0, 0, 2, 1, 2, 1, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEE0, 0), 0, 5'b01110, 32'hDEAD_BEE0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1234, 0), 0, 5'b0, 0, 4'h0));
        foreach (rows[i]) begin
            @(negedge clk);
            reset = rows[i].rst;
            drive(rows[i].s);
            #1;
            obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
            total++;
            if (obs !== rows[i].ctl) begin
                bad++;
                $display("[TB] FAIL branch ctl row %0d got=%b want=%b", i, obs, rows[i].ctl);
            end
            total++;
            if (redirect_pc !== rows[i].pc) begin
                bad++;
                $display("[TB] FAIL branch redirect_pc row %0d got=%h want=%h", i, redirect_pc, rows[i].pc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL branch fwd row %0d got=empty scoreboard want=entry", i);
            end else begin
                ef = sb.pop_front();
                if ({fwd_a_sel, fwd_b_sel} !== ef) begin
                    bad++;
                    $display("[TB] FAIL branch fwd row %0d got=%b want=%b", i, {fwd_a_sel, fwd_b_sel}, ef);
                end
            end
            sb.push_back(rows[i].nf);
        end
    endtask

    task automatic test_raw_stall();
        row_t rows[$];
        logic [4:0] obs;
        logic [3:0] ef;
        rows.push_back(rw(mk(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, FWD ? 4'b0100 : 4'h0));
        rows.push_back(rw(mk(3, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, FWD ? 4'b1000 : 4'h0));
        rows.push_back(rw(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0), 0, FWD ? 5'b0 : STALL, 0, 4'h0));
        rows.push_back(rw(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        foreach (rows[i]) begin
            @(negedge clk);
            reset = rows[i].rst;
            drive(rows[i].s);
            #1;
            obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
            total++;
            if (obs !== rows[i].ctl) begin
                bad++;
                $display("[TB] FAIL raw_stall ctl row %0d got=%b want=%b", i, obs, rows[i].ctl);
            end
            total++;
            if (redirect_pc !== rows[i].pc) begin
                bad++;
                $display("[TB] FAIL raw_stall redirect_pc row %0d got=%h want=%h", i, redirect_pc, rows[i].pc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL raw_stall fwd row %0d got=empty scoreboard want=entry", i);
            end else begin
                ef = sb.pop_front();
                if ({fwd_a_sel, fwd_b_sel} !== ef) begin
                    bad++;
                    $display("[TB] FAIL raw_stall fwd row %0d got=%b want=%b", i, {fwd_a_sel, fwd_b_sel}, ef);
                end
            end
            sb.push_back(rows[i].nf);
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        logic [4:0] obs;
        logic [3:0] ef;
        stim_t noisy;
        noisy = mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 32'h0000_1234, 1);
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0080, 1), 0, 5'b11100, 0, 4'h0));
        rows.push_back(rw(noisy, 0, 5'b11100, 0, 4'h0));
        rows.push_back(rw(noisy, 0, 5'b11100, 0, 4'h0));
        rows.push_back(rw(noisy, 0, 5'b11100, 0, 4'h0));
        rows.push_back(rw(noisy, 0, 5'b11001, 0, 4'h0));
        rows.push_back(rw(noisy, 0, 5'b11001, 0, 4'h0));
        rows.push_back(rw(noisy, 1, 5'b00001, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0044, 0), 0, 5'b01110, 32'h44, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        foreach (rows[i]) begin
            @(negedge clk);
            reset = rows[i].rst;
            drive(rows[i].s);
            #1;
            obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
            total++;
            if (obs !== rows[i].ctl) begin
                bad++;
                $display("[TB] FAIL halt ctl row %0d got=%b want=%b", i, obs, rows[i].ctl);
            end
            total++;
            if (redirect_pc !== rows[i].pc) begin
                bad++;
                $display("[TB] FAIL halt redirect_pc row %0d got=%h want=%h", i, redirect_pc, rows[i].pc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL halt fwd row %0d got=empty scoreboard want=entry", i);
            end else begin
                ef = sb.pop_front();
                if ({fwd_a_sel, fwd_b_sel} !== ef) begin
                    bad++;
                    $display("[TB] FAIL halt fwd row %0d got=%b want=%b", i, {fwd_a_sel, fwd_b_sel}, ef);
                end
            end
            sb.push_back(rows[i].nf);
        end
    endtask

    task automatic test_reset_in_drain();
        row_t rows[$];
        logic [4:0] obs;
        logic [3:0] ef;
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 5'b11100, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b11100, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0048, 0), 1, 5'b00000, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0048, 0), 0, 5'b01110, 32'h48, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        rows.push_back(rw(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 5'b0, 0, 4'h0));
        foreach (rows[i]) begin
            @(negedge clk);
            reset = rows[i].rst;
            drive(rows[i].s);
            #1;
            obs = {stall_if_id, bubble_ex, flush_if_id, redirect_valid, halted};
            total++;
            if (obs !== rows[i].ctl) begin
                bad++;
                $display("[TB] FAIL reset_in_drain ctl row %0d got=%b want=%b", i, obs, rows[i].ctl);
            end
            total++;
            if (redirect_pc !== rows[i].pc) begin
                bad++;
                $display("[TB] FAIL reset_in_drain redirect_pc row %0d got=%h want=%h", i, redirect_pc, rows[i].pc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL reset_in_drain fwd row %0d got=empty scoreboard want=entry", i);
            end else begin
                ef = sb.pop_front();
                if ({fwd_a_sel, fwd_b_sel} !== ef) begin
                    bad++;
                    $display("[TB] FAIL reset_in_drain fwd row %0d got=%b want=%b", i, {fwd_a_sel, fwd_b_sel}, ef);
                end
            end
            sb.push_back(rows[i].nf);
        end
    endtask

    // Time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("[TB] pipe_hazard_ctrl bench, forwarding=%0d", FWD);
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_branch();
        test_raw_stall();
        test_halt();
        test_reset_in_drain();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
